// File: rtl/fetch_unit.sv
// Instruction fetch: reads opcode plus 0-2 operand bytes from a byte memory and presents them to the decoder.
// Latency: N+1 accepted byte cycles, then instr_valid_o on the following cycle (N = operand count).
// Backpressure: memory waits hold mem_addr_o stable; decoder stalls hold the PRESENT outputs stable.
//
// Ports:
//   clk_i, rst_i                    clock, synchronous active-high reset
//   pc_load_i, pc_load_addr_i       redirect request and target (ignored in IDLE)
//   mem_req_o, mem_addr_o           byte read request and address (address is always the PC)
//   mem_valid_i, mem_rdata_i        read byte; accepted when mem_req_o && mem_valid_i
//   instr_valid_o, instr_ready_i    decoder handshake
//   opcode_o, data_o, pc_o          opcode, operand ([7:0] first byte), opcode address
//
// Build option: define FETCH_PREFETCH_EN to fetch the next opcode into a one-byte buffer
// while the decoder is stalling in PRESENT.
module fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h8000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        pc_load_i,
    input  logic [15:0] pc_load_addr_i,
    output logic        mem_req_o,
    output logic [15:0] mem_addr_o,
    input  logic        mem_valid_i,
    input  logic [7:0]  mem_rdata_i,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic [7:0]  opcode_o,
    output logic [15:0] data_o,
    output logic [15:0] pc_o
);

    typedef enum logic [2:0] {IDLE, FETCH_OP, FETCH_LO, FETCH_HI, PRESENT} state_t;

    state_t      state_q;
    logic [15:0] pc_q;
    logic [15:0] pc_d;
    logic [7:0]  opcode_q;
    logic [15:0] data_q;
    logic [15:0] instr_pc_q;
    logic [1:0]  nops_q;
    logic        mem_accept;

`ifdef FETCH_PREFETCH_EN
    logic        buf_vld_q;
    logic [7:0]  buf_dat_q;
    logic [15:0] buf_pc_q;
`endif

    // Operand byte count decoded from opcode fields aaabbbcc.
    function automatic logic [1:0] operand_count(input logic [7:0] op);
        logic [2:0] a;
        logic [2:0] b;
        logic [1:0] n;
        a = op[7:5];
        b = op[4:2];
        n = 2'd0;
        case (op[1:0])
            2'b01: n = (b == 3'd3 || b == 3'd6 || b == 3'd7) ? 2'd2 : 2'd1;
            2'b10: begin
                if (b == 3'd2 || b == 3'd4 || b == 3'd6)  n = 2'd0;
                else if (b == 3'd3 || b == 3'd7)          n = 2'd2;
                else                                      n = 2'd1;
            end
            2'b00: begin
                if (b == 3'd0) begin
                    // b=000 column mixes jump-to-subroutine, implied ops and immediates.
                    if (a == 3'd1)                                  n = 2'd2;
                    else if (a == 3'd0 || a == 3'd2 || a == 3'd3)   n = 2'd0;
                    else                                            n = 2'd1;
                end else if (b == 3'd2 || b == 3'd6)                n = 2'd0;
                else if (b == 3'd3 || b == 3'd7)                    n = 2'd2;
                else                                                n = 2'd1;
            end
            default: n = 2'd0;
        endcase
        return n;
    endfunction

    assign pc_d       = pc_q + 16'd1;
    assign mem_accept = mem_req_o && mem_valid_i;

`ifdef FETCH_PREFETCH_EN
    assign mem_req_o = (state_q == FETCH_OP) || (state_q == FETCH_LO) || (state_q == FETCH_HI) ||
                       ((state_q == PRESENT) && !buf_vld_q && !instr_ready_i);
`else
    assign mem_req_o = (state_q == FETCH_OP) || (state_q == FETCH_LO) || (state_q == FETCH_HI);
`endif

    assign mem_addr_o    = pc_q;
    assign instr_valid_o = (state_q == PRESENT);
    assign opcode_o      = opcode_q;
    assign data_o        = data_q;
    assign pc_o          = instr_pc_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            opcode_q   <= 8'h00;
            data_q     <= 16'h0000;
            instr_pc_q <= 16'h0000;
            nops_q     <= 2'd0;
`ifdef FETCH_PREFETCH_EN
            buf_vld_q  <= 1'b0;
            buf_dat_q  <= 8'h00;
            buf_pc_q   <= 16'h0000;
`endif
        end else if (pc_load_i && state_q != IDLE) begin
            // Any byte accepted this cycle is dropped; a PRESENT transfer already happened.
            state_q   <= FETCH_OP;
            pc_q      <= pc_load_addr_i;
`ifdef FETCH_PREFETCH_EN
            buf_vld_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: state_q <= FETCH_OP;
                FETCH_OP: begin
                    if (mem_accept) begin
                        opcode_q   <= mem_rdata_i;
                        instr_pc_q <= pc_q;
                        data_q     <= 16'h0000;
                        nops_q     <= operand_count(mem_rdata_i);
                        pc_q       <= pc_d;
                        state_q    <= (operand_count(mem_rdata_i) == 2'd0) ? PRESENT : FETCH_LO;
                    end
                end
                FETCH_LO: begin
                    if (mem_accept) begin
                        data_q[7:0] <= mem_rdata_i;
                        pc_q        <= pc_d;
                        state_q     <= (nops_q == 2'd2) ? FETCH_HI : PRESENT;
                    end
                end
                FETCH_HI: begin
                    if (mem_accept) begin
                        data_q[15:8] <= mem_rdata_i;
                        pc_q         <= pc_d;
                        state_q      <= PRESENT;
                    end
                end
                PRESENT: begin
`ifdef FETCH_PREFETCH_EN
                    if (instr_ready_i) begin
                        if (buf_vld_q) begin
                            // Buffered opcode stands in for the FETCH_OP cycle.
                            opcode_q   <= buf_dat_q;
                            instr_pc_q <= buf_pc_q;
                            data_q     <= 16'h0000;
                            nops_q     <= operand_count(buf_dat_q);
                            buf_vld_q  <= 1'b0;
                            state_q    <= (operand_count(buf_dat_q) == 2'd0) ? PRESENT : FETCH_LO;
                        end else begin
                            state_q <= FETCH_OP;
                        end
                    end else if (mem_accept) begin
                        buf_vld_q <= 1'b1;
                        buf_dat_q <= mem_rdata_i;
                        buf_pc_q  <= pc_q;
                        pc_q      <= pc_d;
                    end
`else
                    if (instr_ready_i) begin
                        state_q <= FETCH_OP;
                    end
`endif
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: memory responder with programmable wait states, decoder-side monitor,
// and a queue of expected instructions compared against delivered ones.
module tb_fetch_unit;

    typedef struct packed {
        logic [7:0]  op;
        logic [15:0] dat;
        logic [15:0] pc;
    } instr_t;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        pc_load_i;
    logic [15:0] pc_load_addr_i;
    logic        mem_req_o;
    logic [15:0] mem_addr_o;
    logic        mem_valid_i;
    logic [7:0]  mem_rdata_i;
    logic        instr_valid_o;
    logic        instr_ready_i;
    logic [7:0]  opcode_o;
    logic [15:0] data_o;
    logic [15:0] pc_o;

    logic [7:0]  mem [0:65535];
    instr_t      exp_q[$];
    instr_t      obs_q[$];
    int          obs_cyc[$];
    logic [15:0] addr_q[$];

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int wait_cycles = 0;
    int wcnt = 0;
    int deliver_left = 0;
    bit mem_en = 1'b0;

    fetch_unit #(.RESET_PC(16'h8000)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .pc_load_i      (pc_load_i),
        .pc_load_addr_i (pc_load_addr_i),
        .mem_req_o      (mem_req_o),
        .mem_addr_o     (mem_addr_o),
        .mem_valid_i    (mem_valid_i),
        .mem_rdata_i    (mem_rdata_i),
        .instr_valid_o  (instr_valid_o),
        .instr_ready_i  (instr_ready_i),
        .opcode_o       (opcode_o),
        .data_o         (data_o),
        .pc_o           (pc_o)
    );

    always #5 clk_i = ~clk_i;

    initial forever begin
        @(posedge clk_i);
        cyc = cyc + 1;
    end

    // Memory responder: wait_cycles idle cycles before each byte.
    initial begin
        mem_valid_i = 1'b0;
        mem_rdata_i = 8'h00;
        forever begin
            @(posedge clk_i);
            #2;
            if (mem_en && mem_req_o === 1'b1) begin
                if (wcnt >= wait_cycles) begin
                    mem_valid_i = 1'b1;
                    mem_rdata_i = mem[mem_addr_o];
                    wcnt = 0;
                end else begin
                    mem_valid_i = 1'b0;
                    mem_rdata_i = 8'h00;
                    wcnt = wcnt + 1;
                end
            end else begin
                mem_valid_i = 1'b0;
                wcnt = 0;
            end
        end
    end

    // Monitor: records delivered instructions and accepted byte addresses.
    initial forever begin
        @(negedge clk_i);
        if (instr_valid_o === 1'b1 && instr_ready_i) begin
            obs_q.push_back(instr_t'{opcode_o, data_o, pc_o});
            obs_cyc.push_back(cyc);
            if (deliver_left > 0) begin
                deliver_left = deliver_left - 1;
                if (deliver_left == 0) mem_en = 1'b0;
            end
        end
        if (mem_req_o === 1'b1 && mem_valid_i) addr_q.push_back(mem_addr_o);
    end

    task automatic nstep();
        @(negedge clk_i);
        #1;
    endtask

    task automatic wait_obs(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            nstep();
            if (obs_q.size() >= n) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) nstep();
        total++; if (mem_req_o !== 1'b0) begin bad++; $display("FAIL rst_req: got %b want 0", mem_req_o); end
        total++; if (mem_addr_o !== 16'h8000) begin bad++; $display("FAIL rst_addr: got %h want 8000", mem_addr_o); end
        total++; if (instr_valid_o !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", instr_valid_o); end
        total++; if (opcode_o !== 8'h00) begin bad++; $display("FAIL rst_opcode: got %h want 00", opcode_o); end
        total++; if (data_o !== 16'h0000) begin bad++; $display("FAIL rst_data: got %h want 0000", data_o); end
        total++; if (pc_o !== 16'h0000) begin bad++; $display("FAIL rst_pc: got %h want 0000", pc_o); end
    endtask

    task automatic test_basic();
        bit ok;
        int start;
        instr_t o, e;
        mem[16'h8000] = 8'hA9;
        mem[16'h8001] = 8'h42;
        exp_q.push_back(instr_t'{8'hA9, 16'h0042, 16'h8000});
        addr_q.delete();
        wait_cycles = 0;
        deliver_left = 1;
        mem_en = 1'b1;
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        start = cyc;
        wait_obs(1, 50, ok);
        total++; if (!ok) begin bad++; $display("FAIL basic_timeout: got no transfer want 1"); end
        if (ok) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            total++; if (o !== e) begin bad++; $display("FAIL basic_instr: got %h want %h", o, e); end
            total++; if (obs_cyc[0] - start != 3) begin bad++; $display("FAIL basic_latency: got %0d want 3", obs_cyc[0] - start); end
            void'(obs_cyc.pop_front());
        end
        total++;
        if (addr_q.size() != 2 || addr_q[0] !== 16'h8000 || addr_q[1] !== 16'h8001) begin
            bad++; $display("FAIL basic_addrs: got %0d addrs want 8000,8001", addr_q.size());
        end
        nstep();
        total++; if ({mem_req_o, mem_addr_o} !== {1'b1, 16'h8002}) begin bad++; $display("FAIL basic_next: got %b/%h want 1/8002", mem_req_o, mem_addr_o); end
    endtask

    task automatic test_waits();
        bit ok;
        int unstable;
        int waits;
        instr_t o, e;
        mem[16'h8002] = 8'hAD;
        mem[16'h8003] = 8'h34;
        mem[16'h8004] = 8'h12;
        exp_q.push_back(instr_t'{8'hAD, 16'h1234, 16'h8002});
        addr_q.delete();
        wait_cycles = 2;
        deliver_left = 1;
        mem_en = 1'b1;
        unstable = 0;
        waits = 0;
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            nstep();
            if (mem_req_o === 1'b1 && !mem_valid_i) begin
                waits++;
                if (mem_addr_o !== 16'h8002 + 16'(addr_q.size())) unstable++;
            end
            if (obs_q.size() >= 1) begin
                ok = 1'b1;
                break;
            end
        end
        wait_cycles = 0;
        total++; if (!ok) begin bad++; $display("FAIL waits_timeout: got no transfer want 1"); end
        if (ok) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            void'(obs_cyc.pop_front());
            total++; if (o !== e) begin bad++; $display("FAIL waits_instr: got %h want %h", o, e); end
        end
        total++; if (unstable != 0) begin bad++; $display("FAIL waits_addr_stable: got %0d moves want 0", unstable); end
        total++; if (waits != 6) begin bad++; $display("FAIL waits_count: got %0d want 6", waits); end
        total++;
        if (addr_q.size() != 3 || addr_q[0] !== 16'h8002 || addr_q[1] !== 16'h8003 || addr_q[2] !== 16'h8004) begin
            bad++; $display("FAIL waits_addrs: got %0d addrs want 8002..8004", addr_q.size());
        end
        nstep();
        total++; if ({mem_req_o, mem_addr_o} !== {1'b1, 16'h8005}) begin bad++; $display("FAIL waits_next: got %b/%h want 1/8005", mem_req_o, mem_addr_o); end
    endtask

    task automatic test_nop();
        bit ok;
        instr_t o, e;
        mem[16'h8005] = 8'hEA;
        exp_q.push_back(instr_t'{8'hEA, 16'h0000, 16'h8005});
        addr_q.delete();
        deliver_left = 1;
        mem_en = 1'b1;
        wait_obs(1, 50, ok);
        total++; if (!ok) begin bad++; $display("FAIL nop_timeout: got no transfer want 1"); end
        if (ok) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            void'(obs_cyc.pop_front());
            total++; if (o !== e) begin bad++; $display("FAIL nop_instr: got %h want %h", o, e); end
        end
        total++; if (addr_q.size() != 1 || addr_q[0] !== 16'h8005) begin bad++; $display("FAIL nop_addrs: got %0d addrs want 1 at 8005", addr_q.size()); end
        nstep();
        total++; if ({mem_req_o, mem_addr_o} !== {1'b1, 16'h8006}) begin bad++; $display("FAIL nop_next: got %b/%h want 1/8006", mem_req_o, mem_addr_o); end
    endtask

    task automatic test_back_to_back_hold();
        bit ok;
        bit seen;
        int unst;
        int reqc;
        int exp_req;
        int exp_gap;
        int exp_hold_addrs;
        int c0, c1;
        instr_t o, e;
`ifdef FETCH_PREFETCH_EN
        exp_req = 1; exp_gap = 1; exp_hold_addrs = 3;
`else
        exp_req = 0; exp_gap = 2; exp_hold_addrs = 2;
`endif
        mem[16'h8006] = 8'hA9;
        mem[16'h8007] = 8'h55;
        mem[16'h8008] = 8'hEA;
        exp_q.push_back(instr_t'{8'hA9, 16'h0055, 16'h8006});
        exp_q.push_back(instr_t'{8'hEA, 16'h0000, 16'h8008});
        addr_q.delete();
        instr_ready_i = 1'b0;
        deliver_left = 2;
        mem_en = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            nstep();
            if (instr_valid_o === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        total++; if (!seen) begin bad++; $display("FAIL hold_timeout: got no valid want 1"); end
        unst = 0;
        reqc = 0;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) nstep();
            if ({instr_valid_o, opcode_o, data_o, pc_o} !== {1'b1, 8'hA9, 16'h0055, 16'h8006}) unst++;
            if (mem_req_o === 1'b1) reqc++;
        end
        total++; if (unst != 0) begin bad++; $display("FAIL hold_stable: got %0d changed cycles want 0", unst); end
        total++; if (reqc != exp_req) begin bad++; $display("FAIL hold_req: got %0d want %0d", reqc, exp_req); end
        total++; if (addr_q.size() != exp_hold_addrs) begin bad++; $display("FAIL hold_addrs: got %0d want %0d", addr_q.size(), exp_hold_addrs); end
        @(posedge clk_i);
        #1;
        instr_ready_i = 1'b1;
        wait_obs(2, 50, ok);
        total++; if (!ok) begin bad++; $display("FAIL b2b_timeout: got %0d transfers want 2", obs_q.size()); end
        if (ok) begin
            c0 = obs_cyc.pop_front();
            c1 = obs_cyc.pop_front();
            o = obs_q.pop_front(); e = exp_q.pop_front();
            total++; if (o !== e) begin bad++; $display("FAIL b2b_first: got %h want %h", o, e); end
            o = obs_q.pop_front(); e = exp_q.pop_front();
            total++; if (o !== e) begin bad++; $display("FAIL b2b_second: got %h want %h", o, e); end
            total++; if (c1 - c0 != exp_gap) begin bad++; $display("FAIL b2b_gap: got %0d want %0d", c1 - c0, exp_gap); end
        end
        total++; if (addr_q.size() != 3 || addr_q[2] !== 16'h8008) begin bad++; $display("FAIL b2b_addrs: got %0d want 3 ending 8008", addr_q.size()); end
        nstep();
        total++; if ({mem_req_o, mem_addr_o} !== {1'b1, 16'h8009}) begin bad++; $display("FAIL b2b_next: got %b/%h want 1/8009", mem_req_o, mem_addr_o); end
    endtask

    task automatic test_redirect();
        bit ok;
        bit hit;
        int vcnt;
        instr_t o, e;
        mem[16'h8009] = 8'hAD;
        mem[16'h800A] = 8'h11;
        mem[16'h800B] = 8'h22;
        mem[16'hC000] = 8'hEA;
        addr_q.delete();
        deliver_left = 0;
        mem_en = 1'b1;
        hit = 1'b0;
        for (int i = 0; i < 50; i++) begin
            nstep();
            if (mem_req_o === 1'b1 && mem_valid_i && mem_addr_o === 16'h800B) begin
                hit = 1'b1;
                pc_load_addr_i = 16'hC000;
                pc_load_i = 1'b1;
                mem_en = 1'b0;
                break;
            end
        end
        total++; if (!hit) begin bad++; $display("FAIL redir_reach_hi: got no hi-byte cycle want 1"); end
        nstep();
        pc_load_i = 1'b0;
        total++;
        if ({mem_req_o, mem_addr_o, instr_valid_o} !== {1'b1, 16'hC000, 1'b0}) begin
            bad++; $display("FAIL redir_next: got %b/%h/%b want 1/c000/0", mem_req_o, mem_addr_o, instr_valid_o);
        end
        vcnt = 0;
        for (int i = 0; i < 6; i++) begin
            nstep();
            if (instr_valid_o !== 1'b0) vcnt++;
        end
        total++; if (vcnt != 0 || obs_q.size() != 0) begin bad++; $display("FAIL redir_no_valid: got %0d/%0d want 0/0", vcnt, obs_q.size()); end
        exp_q.push_back(instr_t'{8'hEA, 16'h0000, 16'hC000});
        deliver_left = 1;
        mem_en = 1'b1;
        wait_obs(1, 50, ok);
        total++; if (!ok) begin bad++; $display("FAIL redir_timeout: got no transfer want 1"); end
        if (ok) begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            void'(obs_cyc.pop_front());
            total++; if (o !== e) begin bad++; $display("FAIL redir_instr: got %h want %h", o, e); end
        end
    endtask

    task automatic test_wrap();
        bit ok;
        instr_t o, e;
        pc_load_addr_i = 16'hFFFF;
        pc_load_i = 1'b1;
        nstep();
        pc_load_i = 1'b0;
        mem[16'hFFFF] = 8'h4C;
        mem[16'h0000] = 8'h00;
        mem[16'h0001] = 8'h90;
        addr_q.delete();
        exp_q.push_back(instr_t'{8'h4C, 16'h9000, 16'hFFFF});
        deliver_left = 1;
        mem_en = 1'b1;
        wait_obs(1, 50, ok);
        total++; if (!ok) begin bad++; $display("FAIL wrap_timeout: got no transfer want 1"); end
        if (ok) begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            void'(obs_cyc.pop_front());
            total++; if (o !== e) begin bad++; $display("FAIL wrap_instr: got %h want %h", o, e); end
        end
        total++;
        if (addr_q.size() != 3 || addr_q[0] !== 16'hFFFF || addr_q[1] !== 16'h0000 || addr_q[2] !== 16'h0001) begin
            bad++; $display("FAIL wrap_addrs: got %0d addrs want ffff,0000,0001", addr_q.size());
        end
        nstep();
        total++; if ({mem_req_o, mem_addr_o} !== {1'b1, 16'h0002}) begin bad++; $display("FAIL wrap_next: got %b/%h want 1/0002", mem_req_o, mem_addr_o); end
    endtask

    task automatic test_midreset();
        bit ok;
        bit hit;
        instr_t o, e;
        mem[16'h0002] = 8'hAD;
        mem[16'h0003] = 8'h77;
        mem[16'h0004] = 8'h88;
        addr_q.delete();
        deliver_left = 1;
        mem_en = 1'b1;
        hit = 1'b0;
        for (int i = 0; i < 50; i++) begin
            nstep();
            if (mem_req_o === 1'b1 && mem_valid_i && mem_addr_o === 16'h0004) begin
                hit = 1'b1;
                rst_i = 1'b1;
                mem_en = 1'b0;
                break;
            end
        end
        total++; if (!hit) begin bad++; $display("FAIL mrst_reach_hi: got no hi-byte cycle want 1"); end
        nstep();
        nstep();
        total++;
        if ({mem_req_o, mem_addr_o, instr_valid_o, opcode_o, data_o, pc_o} !==
            {1'b0, 16'h8000, 1'b0, 8'h00, 16'h0000, 16'h0000}) begin
            bad++; $display("FAIL mrst_state: got %b/%h/%b/%h/%h/%h want 0/8000/0/00/0000/0000",
                            mem_req_o, mem_addr_o, instr_valid_o, opcode_o, data_o, pc_o);
        end
        total++; if (obs_q.size() != 0) begin bad++; $display("FAIL mrst_no_partial: got %0d transfers want 0", obs_q.size()); end
        rst_i = 1'b0;
        exp_q.push_back(instr_t'{8'hA9, 16'h0042, 16'h8000});
        deliver_left = 1;
        mem_en = 1'b1;
        wait_obs(1, 50, ok);
        total++; if (!ok) begin bad++; $display("FAIL mrst_timeout: got no transfer want 1"); end
        if (ok) begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            void'(obs_cyc.pop_front());
            total++; if (o !== e) begin bad++; $display("FAIL mrst_refetch: got %h want %h", o, e); end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish want finish by 100000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_i = 1'b1;
        pc_load_i = 1'b0;
        pc_load_addr_i = 16'h0000;
        instr_ready_i = 1'b1;
        test_reset();
        test_basic();
        test_waits();
        test_nop();
        test_back_to_back_hold();
        test_redirect();
        test_wrap();
        test_midreset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
